// File: rtl/mosi_spi_byte_fifo.sv
// Queue of {D/C, word} entries that feeds the SPI MOSI serializer one word at a time.
// Optional status ports (o_LEVEL, o_OVERFLOW) are present when MOSI_FIFO_STATUS_EN is defined.
module mosi_spi_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_SCK,
    input  logic             i_RST,
    input  logic             i_WR_EN,
    input  logic [WIDTH-1:0] i_WR_DATA,
    input  logic             i_WR_DC,
    input  logic             i_FLUSH,
    input  logic             i_MOSI_FINAL_BIT,
    output logic             o_FULL,
    output logic             o_EMPTY,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_DC,
    output logic             o_START,
    output logic             o_MOSI_FINAL_BYTE
`ifdef MOSI_FIFO_STATUS_EN
    ,
    output logic [CW-1:0]    o_LEVEL,
    output logic             o_OVERFLOW
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH:0]    mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              start_next;

    // Status flags come from the registered count only, so a same-edge pop never frees a slot.
    assign o_FULL  = (count == CW'(DEPTH));
    assign o_EMPTY = (count == '0);
    assign push    = i_WR_EN && !o_FULL && !i_FLUSH;

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next        = state;
        pop               = 1'b0;
        start_next        = o_START;
        o_MOSI_FINAL_BYTE = 1'b0;
        case (state)
            IDLE: begin
                if (!o_EMPTY && !i_FLUSH) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = TRANSMIT;
                end
            end
            TRANSMIT: begin
                o_MOSI_FINAL_BYTE = o_EMPTY;
                if (i_MOSI_FINAL_BIT) begin
                    if (!o_EMPTY && !i_FLUSH) begin
                        pop = 1'b1;
                    end else begin
                        start_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge i_SCK) begin
        if (push) begin
            mem[wr_ptr] <= {i_WR_DC, i_WR_DATA};
        end
    end

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            o_DATA  <= '0;
            o_DC    <= 1'b0;
            o_START <= 1'b0;
        end else begin
            o_START <= start_next;
            if (pop) begin
                {o_DC, o_DATA} <= mem[rd_ptr];
            end
            if (i_FLUSH) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef MOSI_FIFO_STATUS_EN
    assign o_LEVEL = count;

    always_ff @(posedge i_SCK) begin
        if (i_RST || i_FLUSH) begin
            o_OVERFLOW <= 1'b0;
        end else if (i_WR_EN && o_FULL) begin
            o_OVERFLOW <= 1'b1;
        end
    end
`endif

endmodule
